// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN dimensions and the pooling row-phase state type
package cnn_pkg;
  localparam int PIX_W = 8;
  localparam int ACC_W = 16;
  localparam int IMG_DIM = 28;
  localparam int POOL_DIM = 14;
  typedef enum logic {ROW_A, ROW_B} pool_state_t;
endpackage

// File: rtl/max4_relu.sv
// max4_relu: combinational signed max of a,b,c,d with optional clamp of negative results to zero on y
module max4_relu import cnn_pkg::*; #(
  parameter int W = ACC_W,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] y
);
  logic signed [W-1:0] ab, cd, m;
  always_comb begin
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    m = ab > cd ? ab : cd;
    y = RELU_EN && m[W-1] ? '0 : m;
  end
endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: 2x2 signed max-pool of conv rows; in_valid/in_ready/in_sof/in_data row input, out_valid/out_ready/out_data/out_last pooled output, sof_err framing pulse
module maxpool_2x2 import cnn_pkg::*; #(
  parameter int N_COL = IMG_DIM,
  parameter int N_ROW = IMG_DIM,
  parameter int W = ACC_W,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [N_COL*W-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(N_COL/2)*W-1:0]   out_data,
  output logic                     out_last,
  output logic                     sof_err
);
  localparam int N_OUT = N_COL / 2;
  localparam int N_PAIR = N_ROW / 2;
  localparam int PW = N_PAIR > 1 ? $clog2(N_PAIR) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_PAIR - 1);
  pool_state_t state;
  logic [PW-1:0] pair;
  logic [N_COL*W-1:0] line_buf;
  logic [N_OUT*W-1:0] pooled;
  logic in_xfer, produce;
  assign in_ready = ~out_valid | out_ready;
  assign in_xfer = in_valid & in_ready;
  assign produce = in_xfer & ~in_sof & (state == ROW_B);
  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    max4_relu #(.W(W), .RELU_EN(RELU_EN)) u_max (
      .a(line_buf[2*W*i +: W]),
      .b(line_buf[2*W*i+W +: W]),
      .c(in_data[2*W*i +: W]),
      .d(in_data[2*W*i+W +: W]),
      .y(pooled[W*i +: W])
    );
  end
  always_ff @(posedge clk)
    if (in_xfer && (in_sof || state == ROW_A)) line_buf <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ROW_A;
      pair <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      sof_err <= in_xfer & in_sof & (state == ROW_B || pair != '0);
      out_valid <= produce | (out_valid & ~out_ready);
      if (produce) begin
        out_data <= pooled;
        out_last <= pair == LAST;
      end
      if (in_xfer) begin
        state <= produce ? ROW_A : ROW_B;
        pair <= in_sof ? '0 : produce ? (pair == LAST ? '0 : pair + 1'b1) : pair;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: scoreboard bench for maxpool_2x2 with a second RELU-off instance
module tb_maxpool_2x2;
  import cnn_pkg::*;
  localparam int N_COL = IMG_DIM;
  localparam int N_ROW = IMG_DIM;
  localparam int W = ACC_W;
  localparam int DW = N_COL * W;
  localparam int OW = (N_COL / 2) * W;
  localparam int NP = N_ROW / 2;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, sof_err;
  logic [DW-1:0] in_data = '0;
  logic [OW-1:0] out_data;
  logic in_valid2 = 1'b0, in_ready2, out_valid2, out_last2, sof_err2;
  logic [63:0] in_data2 = '0;
  logic [31:0] out_data2;
  int n_tests = 0, n_fail = 0;
  logic [OW-1:0] q_data[$];
  logic q_last[$];
  logic m_b = 1'b0;
  int m_pair = 0;
  logic [DW-1:0] m_a;
  int out_cnt = 0, last_cnt = 0, stall_len = 0, stall_seen = 0;
  logic [OW-1:0] held;
  logic held_ok = 1'b0;
  always #5 clk = ~clk;
  maxpool_2x2 #(.N_COL(N_COL), .N_ROW(N_ROW), .W(W), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sof_err(sof_err)
  );
  maxpool_2x2 #(.N_COL(4), .N_ROW(2), .W(16), .RELU_EN(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_sof(1'b0),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
    .out_last(out_last2), .sof_err(sof_err2)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [OW-1:0] pool(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [OW-1:0] r;
    logic signed [W-1:0] v, best;
    r = '0;
    best = '0;
    for (int m = 0; m < N_COL / 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        v = k < 2 ? a[(2*m+k)*W +: W] : b[(2*m+k-2)*W +: W];
        if (k == 0 || v > best) best = v;
      end
      if (best[W-1]) best = '0;
      r[m*W +: W] = best;
    end
    return r;
  endfunction
  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic send_row(input logic [DW-1:0] d, input logic sof);
    int n;
    logic prod, exp_err;
    n = 0;
    prod = 1'b0;
    exp_err = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_sof = sof;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", DW'(in_ready), DW'(1));
    if (sof) begin
      exp_err = m_b || m_pair != 0;
      m_a = d;
      m_b = 1'b1;
      m_pair = 0;
    end else if (!m_b) begin
      m_a = d;
      m_b = 1'b1;
    end else begin
      q_data.push_back(pool(m_a, d));
      q_last.push_back(m_pair == NP - 1);
      m_pair = m_pair == NP - 1 ? 0 : m_pair + 1;
      m_b = 1'b0;
      prod = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    check("sof_err", DW'(sof_err), DW'(exp_err));
    if (prod) check("out_valid_lat", DW'(out_valid), DW'(1));
  endtask
  task automatic send_frame(input int n_rows, input int stall_at);
    for (int i = 0; i < n_rows; i++) begin
      if (i == stall_at) stall_len = 5;
      send_row(rand_row(), i == 0);
    end
  endtask
  always @(negedge clk)
    if (stall_len > 0 && out_valid) begin
      out_ready = 1'b0;
      stall_len--;
    end else out_ready = 1'b1;
  always begin
    @(negedge clk);
    #1;
    if (!out_ready) begin
      stall_seen++;
      check("stall_in_ready", DW'(in_ready), DW'(0));
      if (held_ok) check("stall_hold", DW'(out_data), DW'(held));
      held = out_data;
      held_ok = 1'b1;
    end else held_ok = 1'b0;
  end
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (out_last) last_cnt++;
      if (q_data.size() == 0) check("unexpected_out", DW'(out_valid), DW'(0));
      else begin
        check("out_data", DW'(out_data), DW'(q_data.pop_front()));
        check("out_last", DW'(out_last), DW'(q_last.pop_front()));
      end
    end
  end
  initial begin
    int c0, l0;
    logic [DW-1:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", DW'(out_data), DW'(0));
    check("rst_out_last", DW'(out_last), DW'(0));
    check("rst_sof_err", DW'(sof_err), DW'(0));
    rst = 1'b0;
    in_valid2 = 1'b1;
    in_data2 = {16'h0006, 16'h0005, 16'hFFF8, 16'hFFFD};
    @(negedge clk);
    in_data2 = {16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF};
    @(negedge clk);
    in_valid2 = 1'b0;
    check("raw_valid", DW'(out_valid2), DW'(1));
    check("raw_data", DW'(out_data2), DW'({16'h0006, 16'hFFFF}));
    check("raw_last", DW'(out_last2), DW'(1));
    check("raw_sof_err", DW'(sof_err2), DW'(0));
    check("raw_in_ready", DW'(in_ready2), DW'(1));
    send_row({N_COL{16'h0005}}, 1'b1);
    send_row({N_COL{16'h0007}}, 1'b0);
    check("all7", DW'(out_data), DW'({(N_COL/2){16'h0007}}));
    a = rand_row();
    b = rand_row();
    a[31:0] = {16'hFFF8, 16'hFFFD};
    b[31:0] = {16'hFFFE, 16'hFFFF};
    send_row(a, 1'b0);
    send_row(b, 1'b0);
    check("relu_lane0", DW'(out_data[15:0]), DW'(0));
    send_row(rand_row(), 1'b0);
    send_row(rand_row(), 1'b1);
    @(negedge clk);
    check("sof_pulse_end", DW'(sof_err), DW'(0));
    check("sof_no_out", DW'(out_valid), DW'(0));
    l0 = last_cnt;
    for (int i = 0; i < 27; i++) send_row(rand_row(), 1'b0);
    repeat (3) @(negedge clk);
    check("recover_last", DW'(last_cnt - l0), DW'(1));
    c0 = out_cnt;
    l0 = last_cnt;
    send_frame(28, -1);
    repeat (3) @(negedge clk);
    check("frame1_outs", DW'(out_cnt - c0), DW'(NP));
    check("frame1_last", DW'(last_cnt - l0), DW'(1));
    c0 = out_cnt;
    l0 = last_cnt;
    send_frame(28, 10);
    repeat (3) @(negedge clk);
    check("frame2_outs", DW'(out_cnt - c0), DW'(NP));
    check("frame2_last", DW'(last_cnt - l0), DW'(1));
    check("stall_cycles", DW'(stall_seen), DW'(5));
    send_frame(9, -1);
    rst = 1'b1;
    q_data.delete();
    q_last.delete();
    m_b = 1'b0;
    m_pair = 0;
    @(negedge clk);
    check("midrst_valid", DW'(out_valid), DW'(0));
    check("midrst_last", DW'(out_last), DW'(0));
    rst = 1'b0;
    c0 = out_cnt;
    l0 = last_cnt;
    send_frame(28, -1);
    repeat (3) @(negedge clk);
    check("post_rst_outs", DW'(out_cnt - c0), DW'(NP));
    check("post_rst_last", DW'(last_cnt - l0), DW'(1));
    check("queue_empty", DW'(q_data.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2.md
MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 Parameter N_COL, 28, convolution output columns per row (even).
REQ-002 Parameter N_ROW, 28, rows per frame (even).
REQ-003 Parameter W, 16, signed element width.
REQ-004 Parameter RELU_EN, 1, clamp negative results to 0 when 1.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input row present.
REQ-008 in_ready  out  1  block accepts input row this cycle.
REQ-009 in_sof  in  1  qualifies first row of a frame.
REQ-010 in_data  in  N_COL*W  one conv row; element k at bits [W*k+W-1 : W*k], k=0 is column 0, two's complement.
REQ-011 out_valid  out  1  pooled row present.
REQ-012 out_ready  in  1  downstream accepts pooled row.
REQ-013 out_data  out  (N_COL/2)*W  pooled row; lane m at [W*m+W-1 : W*m].
REQ-014 out_last  out  1  marks pooled row N_ROW/2-1 of a frame.
REQ-015 sof_err  out  1  one-cycle pulse on framing violation.

Function
REQ-016 Input transfer occurs when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-017 in_ready = ~out_valid | out_ready (combinational, no dependency on in_valid).
REQ-018 FSM states ROW_A, ROW_B; ROW_A on transfer stores in_data in line buffer, goes ROW_B.
REQ-019 ROW_B on transfer computes lane m = signed max(A[2m], A[2m+1], B[2m], B[2m+1]), goes ROW_A.
REQ-020 If RELU_EN=1, negative lane result becomes 0; else raw max passed.
REQ-021 Result registered into out_data with out_valid=1 the cycle after the ROW_B transfer (latency 1).
REQ-022 out_data, out_last held stable while out_valid & ~out_ready.
REQ-023 Output transfer and new ROW_B result in same cycle: register reloads, out_valid stays 1.
REQ-024 Output transfer with no new result: out_valid drops to 0 next cycle.
REQ-025 Pair counter 0..N_ROW/2-1 increments per produced row; out_last=1 with pair N_ROW/2-1; counter wraps to 0.
REQ-026 Transfer with in_sof=1: row taken as ROW_A of a new frame, pair counter cleared, prior buffered row discarded.
REQ-027 sof_err pulses when in_sof transfer occurs in ROW_B or with pair counter nonzero; recovery per REQ-026.
REQ-028 in_sof=1 in ROW_A with pair counter 0 is legal, no pulse; in_sof absent at frame start is tolerated.
REQ-029 No combinational path from in_data to any output.

Reset
REQ-030 On rst: state ROW_A, pair counter 0, out_valid 0, out_data 0, out_last 0, sof_err 0.
REQ-031 Line buffer not reset; contents unused until rewritten.
REQ-032 rst mid-frame discards partial frame and pending output; first transfer after reset is ROW_A.

Structure
REQ-033 Shared package cnn_pkg holds PIX_W=8, ACC_W=16, IMG_DIM=28, POOL_DIM=14; parameter defaults come from it.
REQ-034 One sub-module max4_relu (four W-bit signed inputs, RELU_EN, one output), instantiated N_COL/2 times, purely combinational.

Verification
REQ-035 A row all lanes 5, B row all 7, out_ready=1 -> every lane 0x0007, out_valid 1 cycle after B transfer.
REQ-036 A lane pair (-3,-8), B (-1,-2): RELU_EN=1 -> 0x0000; RELU_EN=0 -> 0xFFFF.
REQ-037 28 back-to-back rows, out_ready=1 -> exactly 14 outputs, out_last only on 14th, second frame out_last again on its 14th.
REQ-038 out_ready=0 for 5 cycles while out_valid -> in_ready=0, out_data unchanged, no input row lost, outputs in order after release.
REQ-039 Row A then in_sof row -> sof_err pulse 1 cycle, no output, next row pairs with sof row.
REQ-040 rst after 9 rows -> out_valid=0 next cycle, following 28-row frame yields 14 correct outputs.
